td4_prog_encoder: RTL and testbench

//   Inverse of the TD4 instruction decoder: accepts datapath-control tuples (load one-hot, ALU

---
 rtl/td4_prog_encoder_if.sv | 11 +
 rtl/td4_prog_encoder.sv | 86 ++++++++
 tb/tb_td4_prog_encoder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/td4_prog_encoder_if.sv
// td4_prog_encoder_if: valid/ready encode-request channel into the TD4 program encoder
interface td4_prog_encoder_if #(parameter int IMM_W = 4);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_load;
    logic [1:0]       in_select;
    logic             in_cond;
    logic [IMM_W-1:0] in_imm;
    modport master (output in_valid, in_load, in_select, in_cond, in_imm, input in_ready);
    modport slave (input in_valid, in_load, in_select, in_cond, in_imm, output in_ready);
endinterface

// File: rtl/td4_prog_encoder.sv
// td4_prog_encoder: encodes TD4 control tuples into instructions and loads them into program memory
module td4_prog_encoder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 4
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                start,
    input  logic                finish,
    td4_prog_encoder_if.slave   bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic [ADDR_W:0]     wr_count,
    output logic                err_illegal,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic [3+IMM_W:0]    fetch_data
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST = FULL - 1'b1;
    state_t state, state_n;
    logic [ADDR_W-1:0] wr_ptr;
    logic [3+IMM_W:0] mem [DEPTH];
    logic [3:0] opcode;
    logic legal, xfer, wr_en;
    always_comb begin
        legal = 1'b1;
        opcode = 4'b0000;
        case ({bus.in_load, bus.in_select, bus.in_cond})
            7'b0001_11_0: opcode = 4'b0011;
            7'b0001_01_0: opcode = 4'b0001;
            7'b0001_00_0: opcode = 4'b0000;
            7'b0001_10_0: opcode = 4'b0010;
            7'b0010_11_0: opcode = 4'b0111;
            7'b0010_00_0: opcode = 4'b0100;
            7'b0010_01_0: opcode = 4'b0101;
            7'b0010_10_0: opcode = 4'b0110;
            7'b0100_11_0: opcode = 4'b1011;
            7'b0100_01_0: opcode = 4'b1001;
            7'b1000_11_0: opcode = 4'b1111;
            7'b1000_11_1: opcode = 4'b1110;
            default:      legal  = 1'b0;
        endcase
    end
    always_comb begin
        busy = state == LOAD;
        cpu_hold = busy;
        bus.in_ready = busy && wr_count < FULL;
        xfer = bus.in_valid && bus.in_ready;
        wr_en = xfer && legal;
        state_n = state;
        if (start)
            state_n = LOAD;
        else if (state == LOAD && (finish || (wr_en && wr_count == LAST)))
            state_n = DONE;
        else if (state == DONE)
            state_n = IDLE;
    end
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            state <= IDLE;
        else
            state <= state_n;
    end
    // start takes priority over a coincident transfer: the session restarts cleanly
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            wr_count <= '0;
            err_illegal <= 1'b0;
            mem <= '{default: '0};
        end else if (start) begin
            wr_ptr <= '0;
            wr_count <= '0;
            err_illegal <= 1'b0;
        end else if (wr_en) begin
            mem[wr_ptr] <= {opcode, bus.in_imm};
            wr_ptr <= wr_ptr + 1'b1;
            wr_count <= wr_count + 1'b1;
        end else if (xfer) begin
            err_illegal <= 1'b1;
        end
    end
    assign fetch_data = mem[fetch_addr];
endmodule

// File: tb/tb_td4_prog_encoder.sv
// tb_td4_prog_encoder: directed self-checking bench for the TD4 program encoder
module tb_td4_prog_encoder;
    logic clk = 1'b0, n_reset = 1'b0, start = 1'b0, finish = 1'b0;
    logic cpu_hold, busy, err_illegal;
    logic [4:0] wr_count;
    logic [3:0] fetch_addr = '0;
    logic [7:0] fetch_data;
    int n_checks = 0, n_fail = 0;
    td4_prog_encoder_if #(.IMM_W(4)) bus ();
    td4_prog_encoder dut (
        .clk(clk), .n_reset(n_reset), .start(start), .finish(finish), .bus(bus),
        .cpu_hold(cpu_hold), .busy(busy), .wr_count(wr_count), .err_illegal(err_illegal),
        .fetch_addr(fetch_addr), .fetch_data(fetch_data)
    );
    always #5 clk = ~clk;
    // {load, select, cond, expected opcode}
    localparam logic [10:0] TBL [12] = '{
        11'b0001_11_0_0011, 11'b0001_01_0_0001, 11'b0001_00_0_0000, 11'b0001_10_0_0010,
        11'b0010_11_0_0111, 11'b0010_00_0_0100, 11'b0010_01_0_0101, 11'b0010_10_0_0110,
        11'b0100_11_0_1011, 11'b0100_01_0_1001, 11'b1000_11_0_1111, 11'b1000_11_1_1110
    };
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic pulse_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask
    task automatic send(input logic [3:0] ld, input logic [1:0] sel, input logic cnd, input logic [3:0] imm);
        bus.in_load = ld;
        bus.in_select = sel;
        bus.in_cond = cnd;
        bus.in_imm = imm;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask
    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_load = '0;
        bus.in_select = '0;
        bus.in_cond = 1'b0;
        bus.in_imm = '0;
        tick();
        tick();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        n_checks++; if (cpu_hold !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold got=%b%b exp=00", cpu_hold, busy); end
        n_checks++; if (wr_count !== 5'd0 || err_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_cnt got=%0d/%b exp=0/0", wr_count, err_illegal); end
        n_checks++; if (fetch_data !== 8'h00) begin n_fail++; $display("FAIL reset_mem got=%h exp=00", fetch_data); end
        n_reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask
    task automatic test_single();
        pulse_start();
        n_checks++; if (busy !== 1'b1 || cpu_hold !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL load_entry got=%b%b%b exp=111", busy, cpu_hold, bus.in_ready); end
        send(4'b0001, 2'b11, 1'b0, 4'h5);
        fetch_addr = 4'd0;
        #1;
        n_checks++; if (fetch_data !== 8'h35) begin n_fail++; $display("FAIL single_mem got=%h exp=35", fetch_data); end
        n_checks++; if (wr_count !== 5'd1 || err_illegal !== 1'b0) begin n_fail++; $display("FAIL single_cnt got=%0d/%b exp=1/0", wr_count, err_illegal); end
    endtask
    task automatic test_all_legal();
        logic [10:0] t;
        pulse_start();
        n_checks++; if (wr_count !== 5'd0) begin n_fail++; $display("FAIL restart_cnt got=%0d exp=0", wr_count); end
        for (int i = 0; i < 12; i++) begin
            t = TBL[i];
            send(t[10:7], t[6:5], t[4], 4'(i));
        end
        n_checks++; if (wr_count !== 5'd12) begin n_fail++; $display("FAIL legal_cnt got=%0d exp=12", wr_count); end
        pulse_finish();
        n_checks++; if (cpu_hold !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL done_outputs got=%b%b%b exp=000", cpu_hold, busy, bus.in_ready); end
        tick();
        n_checks++; if (cpu_hold !== 1'b0 || wr_count !== 5'd12) begin n_fail++; $display("FAIL idle_after_done got=%b/%0d exp=0/12", cpu_hold, wr_count); end
        for (int i = 0; i < 12; i++) begin
            t = TBL[i];
            fetch_addr = 4'(i);
            #1;
            n_checks++; if (fetch_data !== {t[3:0], 4'(i)}) begin n_fail++; $display("FAIL legal_mem[%0d] got=%h exp=%h", i, fetch_data, {t[3:0], 4'(i)}); end
        end
        fetch_addr = 4'd12;
        #1;
        n_checks++; if (fetch_data !== 8'h00) begin n_fail++; $display("FAIL legal_mem12 got=%h exp=00", fetch_data); end
    endtask
    task automatic test_illegal();
        pulse_start();
        bus.in_load = 4'b0011;
        bus.in_select = 2'b11;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready got=%b exp=1", bus.in_ready); end
        send(4'b0011, 2'b11, 1'b0, 4'h7);
        n_checks++; if (err_illegal !== 1'b1 || wr_count !== 5'd0) begin n_fail++; $display("FAIL illegal1 got=%b/%0d exp=1/0", err_illegal, wr_count); end
        send(4'b0001, 2'b11, 1'b1, 4'h9);
        fetch_addr = 4'd0;
        #1;
        n_checks++; if (wr_count !== 5'd0 || fetch_data !== 8'h30) begin n_fail++; $display("FAIL illegal2 got=%0d/%h exp=0/30", wr_count, fetch_data); end
        send(4'b0001, 2'b00, 1'b0, 4'h2);
        #1;
        n_checks++; if (err_illegal !== 1'b1 || wr_count !== 5'd1 || fetch_data !== 8'h02) begin n_fail++; $display("FAIL illegal_sticky got=%b/%0d/%h exp=1/1/02", err_illegal, wr_count, fetch_data); end
        pulse_start();
        n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear got=%b exp=0", err_illegal); end
        pulse_finish();
        tick();
    endtask
    task automatic test_back_to_back();
        pulse_start();
        bus.in_load = 4'b0010;
        bus.in_select = 2'b00;
        bus.in_cond = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_imm = 4'(i);
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, bus.in_ready); end
            tick();
        end
        n_checks++; if (bus.in_ready !== 1'b0 || wr_count !== 5'd16 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_full got=%b/%0d/%b exp=0/16/0", bus.in_ready, wr_count, busy); end
        bus.in_imm = 4'hC;
        tick();
        tick();
        bus.in_valid = 1'b0;
        fetch_addr = 4'd0;
        #1;
        n_checks++; if (wr_count !== 5'd16 || fetch_data !== 8'h40) begin n_fail++; $display("FAIL b2b_17th got=%0d/%h exp=16/40", wr_count, fetch_data); end
        fetch_addr = 4'd15;
        #1;
        n_checks++; if (fetch_data !== 8'h4F) begin n_fail++; $display("FAIL b2b_mem15 got=%h exp=4f", fetch_data); end
    endtask
    task automatic test_finish_coincident();
        pulse_start();
        finish = 1'b1;
        send(4'b1000, 2'b11, 1'b1, 4'hA);
        finish = 1'b0;
        fetch_addr = 4'd0;
        #1;
        n_checks++; if (fetch_data !== 8'hEA || wr_count !== 5'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL fin_coinc got=%h/%0d/%b exp=ea/1/0", fetch_data, wr_count, busy); end
        start = 1'b1;
        finish = 1'b1;
        tick();
        start = 1'b0;
        finish = 1'b0;
        n_checks++; if (busy !== 1'b1 || wr_count !== 5'd0) begin n_fail++; $display("FAIL start_vs_finish got=%b/%0d exp=1/0", busy, wr_count); end
    endtask
    task automatic test_reset_mid();
        pulse_start();
        for (int i = 0; i < 5; i++) send(4'b0100, 2'b01, 1'b0, 4'(i));
        fetch_addr = 4'd4;
        #1;
        n_checks++; if (fetch_data !== 8'h94 || busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset got=%h/%b exp=94/1", fetch_data, busy); end
        #2 n_reset = 1'b0;
        #1;
        n_checks++; if (cpu_hold !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0 || wr_count !== 5'd0 || err_illegal !== 1'b0) begin n_fail++; $display("FAIL mid_reset got=%b%b%b/%0d/%b exp=000/0/0", cpu_hold, busy, bus.in_ready, wr_count, err_illegal); end
        for (int i = 0; i < 5; i++) begin
            fetch_addr = 4'(i);
            #1;
            n_checks++; if (fetch_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_mem[%0d] got=%h exp=00", i, fetch_data); end
        end
        tick();
        n_reset = 1'b1;
        tick();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        test_reset();
        test_single();
        test_all_legal();
        test_illegal();
        test_back_to_back();
        test_finish_coincident();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
